// File: rtl/multi_edge_parity.sv
// -----------------------------------------------------------------------------
// multi_edge_parity
//
// Per-channel edge counter and parity tracker for slow front-panel inputs
// (switches, buttons). A free-running divider produces a one-clock sampling
// tick. On each tick every channel:
//   * shifts its raw input through a 2-FF synchroniser,
//   * remembers the previous synchronised value,
//   * detects the selected edge type and, if one is seen, counts it.
// Each counted edge toggles the channel's parity and bumps its counter.
//
// Ports
//   clk_100Mhz : system clock, all state updates on its rising edge
//   reset      : synchronous, active-high reset
//   in[CH]     : raw asynchronous channel inputs
//   mode[2]    : 00 rising, 01 falling, 10 both, 11 counting disabled
//   clear[CH]  : per-channel synchronous clear of counter and parity
//   tick       : sampling strobe, one clock wide, every DIV clocks
//   edge_pulse : one-clock pulse per detected edge (also when cleared)
//   led_even   : channel has counted an even number of edges
//   led_odd    : channel has counted an odd number of edges
//   count      : per-channel counters, channel i at [i*CNT_W +: CNT_W]
//   any_odd    : OR of all led_odd bits
// -----------------------------------------------------------------------------
module multi_edge_parity #(
    parameter int unsigned CH    = 4,
    parameter int unsigned DIV   = 10000000,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk_100Mhz,
    input  logic                  reset,
    input  logic [CH-1:0]         in,
    input  logic [1:0]            mode,
    input  logic [CH-1:0]         clear,
    output logic                  tick,
    output logic [CH-1:0]         edge_pulse,
    output logic [CH-1:0]         led_even,
    output logic [CH-1:0]         led_odd,
    output logic [CH*CNT_W-1:0]   count,
    output logic                  any_odd
);

    // Divider counter needs at least one bit even when DIV is 1.
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    logic [DIV_W-1:0] div_cnt;
    logic [CH-1:0]    ff1;
    logic [CH-1:0]    ff2;
    logic [CH-1:0]    prev;
    logic [CH-1:0]    sel;
    logic [CH-1:0]    hit;

    // Sampling divider: tick is registered, so it is high in the clock after
    // the counter reaches its last value.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Synchroniser and history, advanced only on the sampling tick.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            ff1  <= '0;
            ff2  <= '0;
            prev <= '0;
        end else if (tick) begin
            ff1  <= in;
            ff2  <= ff1;
            prev <= ff2;
        end
    end

    // Edge selection from the synchronised value and its predecessor.
    always_comb begin
        sel = '0;
        case (mode)
            MODE_RISE: sel = ff2 & ~prev;
            MODE_FALL: sel = ~ff2 & prev;
            MODE_BOTH: sel = ff2 ^ prev;
            default:   sel = '0;
        endcase
    end

    // An edge is only acted on in the tick cycle, where the history is valid.
    assign hit = tick ? sel : '0;

    // Counters and parity. clear wins over a simultaneous edge for count and
    // parity, but the pulse still reports the edge.
    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            edge_pulse <= '0;
            count      <= '0;
            led_even   <= '1;
            led_odd    <= '0;
        end else begin
            edge_pulse <= hit;
            for (int unsigned i = 0; i < CH; i++) begin
                if (clear[i]) begin
                    count[i*CNT_W +: CNT_W] <= '0;
                    led_even[i]             <= 1'b1;
                    led_odd[i]              <= 1'b0;
                end else if (hit[i]) begin
                    count[i*CNT_W +: CNT_W] <= count[i*CNT_W +: CNT_W] + CNT_W'(1);
                    led_even[i]             <= led_odd[i];
                    led_odd[i]              <= led_even[i];
                end
            end
        end
    end

    assign any_odd = |led_odd;

endmodule

// File: tb/tb_multi_edge_parity.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_parity
//
// Directed bench for multi_edge_parity (CH=4, DIV=4, CNT_W=4). A behavioural
// model keeps, per channel, the list of values sampled at past ticks and the
// total number of counted edges; an edge is counted when the value sampled
// two ticks ago differs from the one sampled three ticks ago in the selected
// direction. Every clock the DUT outputs are compared with the model, and
// hand-computed literals pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_multi_edge_parity;

    localparam int unsigned CH    = 4;
    localparam int unsigned DIV   = 4;
    localparam int unsigned CNT_W = 4;

    logic                clk_100Mhz = 1'b0;
    logic                reset;
    logic [CH-1:0]       in;
    logic [1:0]          mode;
    logic [CH-1:0]       clear;
    logic                tick;
    logic [CH-1:0]       edge_pulse;
    logic [CH-1:0]       led_even;
    logic [CH-1:0]       led_odd;
    logic [CH*CNT_W-1:0] count;
    logic                any_odd;

    multi_edge_parity #(.CH(CH), .DIV(DIV), .CNT_W(CNT_W)) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .in         (in),
        .mode       (mode),
        .clear      (clear),
        .tick       (tick),
        .edge_pulse (edge_pulse),
        .led_even   (led_even),
        .led_odd    (led_odd),
        .count      (count),
        .any_odd    (any_odd)
    );

    always #5 clk_100Mhz = ~clk_100Mhz;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned ncyc  = 0;

    // Model state
    bit              model_ok = 1'b0;
    int unsigned     n_since;          // clocks since reset release
    logic            tick_m;
    logic [CH-1:0]   pulse_m;
    logic [CH-1:0]   hist[$];          // hist[0] = most recent tick sample
    int unsigned     tot[CH];
    int unsigned     pcount[CH];       // DUT pulses observed per channel

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic [CH-1:0] newer;
        logic [CH-1:0] older;
        if (reset) begin
            model_ok = 1'b1;
            n_since  = 0;
            tick_m   = 1'b0;
            pulse_m  = '0;
            hist.delete();
            repeat (3) hist.push_front('0);
            for (int i = 0; i < CH; i++) tot[i] = 0;
        end else begin
            pulse_m = '0;
            if (tick_m) begin
                newer = hist[1];
                older = hist[2];
                for (int i = 0; i < CH; i++) begin
                    bit take;
                    case (mode)
                        2'b00:   take = newer[i] && !older[i];
                        2'b01:   take = !newer[i] && older[i];
                        2'b10:   take = newer[i] != older[i];
                        default: take = 1'b0;
                    endcase
                    if (take) begin
                        pulse_m[i] = 1'b1;
                        tot[i]++;
                    end
                end
                hist.push_front(in);
                if (hist.size() > 3) void'(hist.pop_back());
            end
            for (int i = 0; i < CH; i++) begin
                if (clear[i]) tot[i] = 0;
            end
            n_since++;
            tick_m = ((n_since % DIV) == 0);
        end
    endtask

    task automatic compare();
        logic [CH*CNT_W-1:0] exp_cnt;
        logic [CH-1:0]       exp_odd;
        logic [CH-1:0]       exp_even;
        for (int i = 0; i < CH; i++) begin
            exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(tot[i]);
            exp_odd[i]                = tot[i][0];
        end
        exp_even = ~exp_odd;
        chk("tick", 32'(tick), 32'(tick_m));
        chk("edge_pulse", 32'(edge_pulse), 32'(pulse_m));
        chk("count", 32'(count), 32'(exp_cnt));
        chk("led_odd", 32'(led_odd), 32'(exp_odd));
        chk("led_even", 32'(led_even), 32'(exp_even));
        chk("any_odd", 32'(any_odd), 32'(|exp_odd));
    endtask

    // One or more clocks: model update at the edge, checks 2 ns later.
    task automatic step(input int k);
        for (int j = 0; j < k; j++) begin
            @(posedge clk_100Mhz);
            model_edge();
            ncyc++;
            #2;
            if (model_ok) compare();
            for (int i = 0; i < CH; i++) begin
                if (edge_pulse[i] === 1'b1) pcount[i]++;
            end
        end
    endtask

    // Move to just after a sampling edge (ticks sample at ncyc % 4 == 1).
    task automatic align();
        while ((ncyc % DIV) != 1) step(1);
    endtask

    initial begin
        logic [7:0] tick_pat;
        tick_pat = 8'b1000_1000;
        reset = 1'b1;
        in    = '0;
        mode  = 2'b00;
        clear = '0;

        // 1. reset state and tick cadence
        step(3);
        chk("rst_led_even", 32'(led_even), 32'h0000_000F);
        chk("rst_led_odd", 32'(led_odd), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        ncyc  = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("tick_cadence", 32'(tick), 32'(tick_pat[k-1]));
        end

        // 2. rising edge held on ch0, counted at the third tick
        align();
        in[0] = 1'b1;
        step(12);
        chk("t2_pulse", 32'(edge_pulse), 32'h1);
        chk("t2_cnt0", 32'(count[3:0]), 32'h1);
        chk("t2_odd0", 32'(led_odd[0]), 32'h1);
        chk("t2_any_odd", 32'(any_odd), 32'h1);
        step(1);
        chk("t2_pulse_width", 32'(edge_pulse), 32'h0);
        step(40);
        chk("t2_cnt0_held", 32'(count[3:0]), 32'h1);

        // 3. both-edge mode, 5 toggles on ch1
        mode = 2'b10;
        align();
        for (int i = 0; i < CH; i++) pcount[i] = 0;
        for (int k = 0; k < 5; k++) begin
            in[1] = ~in[1];
            step(8);
        end
        step(16);
        chk("t3_pulses1", 32'(pcount[1]), 32'd5);
        chk("t3_cnt1", 32'(count[7:4]), 32'h5);
        chk("t3_odd1", 32'(led_odd[1]), 32'h1);
        chk("t3_cnt0", 32'(count[3:0]), 32'h1);
        chk("t3_cnt23", 32'(count[15:8]), 32'h0);

        // 4. 17 rising edges on ch2 wrap the 4-bit counter to 1
        mode = 2'b00;
        align();
        for (int k = 0; k < 17; k++) begin
            in[2] = 1'b1;
            step(4);
            in[2] = 1'b0;
            step(4);
        end
        step(16);
        chk("t4_cnt2_wrap", 32'(count[11:8]), 32'h1);
        chk("t4_odd2", 32'(led_odd[2]), 32'h1);

        // 5. clear[3] coincides with a counted edge, count at 6 beforehand
        align();
        for (int k = 0; k < 6; k++) begin
            in[3] = 1'b1;
            step(4);
            in[3] = 1'b0;
            step(4);
        end
        step(16);
        chk("t5_cnt3_pre", 32'(count[15:12]), 32'h6);
        align();
        in[3] = 1'b1;
        step(11);
        clear[3] = 1'b1;
        step(1);
        clear[3] = 1'b0;
        chk("t5_cnt3_clr", 32'(count[15:12]), 32'h0);
        chk("t5_even3", 32'(led_even[3]), 32'h1);
        chk("t5_pulse3", 32'(edge_pulse[3]), 32'h1);
        step(8);
        chk("t5_cnt3_after", 32'(count[15:12]), 32'h0);

        // 6. disabled mode, glitch rejection, falling-only mode
        mode = 2'b11;
        align();
        for (int k = 0; k < 4; k++) begin
            in[0] = ~in[0];
            step(8);
        end
        step(16);
        chk("t6_disabled", 32'(count[3:0]), 32'h1);
        mode = 2'b01;
        align();
        step(1);
        in[0] = 1'b0;
        step(2);
        in[0] = 1'b1;
        step(16);
        chk("t6_glitch", 32'(count[3:0]), 32'h1);
        in[0] = 1'b0;
        step(16);
        chk("t6_fall_cnt", 32'(count[3:0]), 32'h2);
        chk("t6_fall_even", 32'(led_odd[0]), 32'h0);
        in[0] = 1'b1;
        step(16);
        chk("t6_rise_ignored", 32'(count[3:0]), 32'h2);

        // Reset in mid-operation returns everything to reset values
        reset = 1'b1;
        step(1);
        chk("rst2_count", 32'(count), 32'h0);
        chk("rst2_led_even", 32'(led_even), 32'h0000_000F);
        chk("rst2_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        ncyc  = 0;
        step(24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
